// File: rtl/ex_alu_stage.sv
// ex_alu_stage: SimpleRISC execute stage. Single-cycle ALU ops plus
// iterative 32-step shift-add multiply and restoring divide/modulo,
// feeding the EX/DM pipeline register.
module ex_alu_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] imm,
  input  logic             is_imm,
  input  logic [4:0]       rd_in,
  output logic             stall,
  output logic             valid_DM,
  output logic [4:0]       rd_DM,
  output logic [WIDTH-1:0] result_DM,
  output logic             flag_E,
  output logic             flag_GT
);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_DIV = 5'd3;
  localparam logic [4:0] OP_MOD = 5'd4;
  localparam logic [4:0] OP_CMP = 5'd5;
  localparam logic [4:0] OP_AND = 5'd6;
  localparam logic [4:0] OP_OR  = 5'd7;
  localparam logic [4:0] OP_NOT = 5'd8;
  localparam logic [4:0] OP_MOV = 5'd9;
  localparam logic [4:0] OP_LSL = 5'd10;
  localparam logic [4:0] OP_LSR = 5'd11;
  localparam logic [4:0] OP_ASR = 5'd12;
  localparam logic [4:0] OP_NOP = 5'd13;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] acc;
  logic [4:0]       cap_op;
  logic [4:0]       cap_rd;

  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] alu_res;
  logic             starts_multi;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] final_res;

  // stall depends on state alone so there is no input-to-stall path
  assign stall = (state == BUSY);

  // operand select and single-cycle result; divide by zero resolves here
  always_comb begin
    op2          = is_imm ? imm : B;
    alu_res      = A + op2;
    starts_multi = (op == OP_MUL) ||
                   (((op == OP_DIV) || (op == OP_MOD)) && (op2 != {WIDTH{1'b0}}));
    case (op)
      OP_SUB:  alu_res = A - op2;
      OP_DIV:  alu_res = {WIDTH{1'b1}};
      OP_MOD:  alu_res = A;
      OP_AND:  alu_res = A & op2;
      OP_OR:   alu_res = A | op2;
      OP_NOT:  alu_res = ~op2;
      OP_MOV:  alu_res = op2;
      OP_LSL:  alu_res = A << op2[4:0];
      OP_LSR:  alu_res = A >> op2[4:0];
      OP_ASR:  alu_res = $signed(A) >>> op2[4:0];
      default: alu_res = A + op2;
    endcase
  end

  // one multiply or divide step; reg_a is multiplicand or dividend/quotient
  always_comb begin
    acc_nxt   = acc;
    a_nxt     = reg_a;
    b_nxt     = reg_b;
    rem_sh    = {acc, reg_a[WIDTH-1]};
    trial     = rem_sh - {1'b0, reg_b};
    final_res = acc;
    if (cap_op == OP_MUL) begin
      acc_nxt   = acc + (reg_b[0] ? reg_a : {WIDTH{1'b0}});
      a_nxt     = reg_a << 1;
      b_nxt     = reg_b >> 1;
      final_res = acc_nxt;
    end else begin
      if (!trial[WIDTH]) begin
        acc_nxt = trial[WIDTH-1:0];
        a_nxt   = {reg_a[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        a_nxt   = {reg_a[WIDTH-2:0], 1'b0};
      end
      final_res = (cap_op == OP_DIV) ? a_nxt : acc_nxt;
    end
  end

  // IDLE/BUSY control, iteration registers and the EX/DM register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      reg_a     <= '0;
      reg_b     <= '0;
      acc       <= '0;
      cap_op    <= 5'd0;
      cap_rd    <= 5'd0;
      valid_DM  <= 1'b0;
      rd_DM     <= 5'd0;
      result_DM <= '0;
      flag_E    <= 1'b0;
      flag_GT   <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      valid_DM <= 1'b0;
      rd_DM    <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          valid_DM <= 1'b0;
          rd_DM    <= 5'd0;
          if (valid_in) begin
            if (starts_multi) begin
              reg_a  <= A;
              reg_b  <= op2;
              acc    <= '0;
              cap_op <= op;
              cap_rd <= rd_in;
              cnt    <= 6'd32;
              state  <= BUSY;
            end else if (op == OP_CMP) begin
              valid_DM <= 1'b1;
              flag_E   <= (A == op2);
              flag_GT  <= ($signed(A) > $signed(op2));
            end else if (op == OP_NOP) begin
              valid_DM <= 1'b1;
            end else begin
              valid_DM  <= 1'b1;
              rd_DM     <= rd_in;
              result_DM <= alu_res;
            end
          end
        end
        BUSY: begin
          acc   <= acc_nxt;
          reg_a <= a_nxt;
          reg_b <= b_nxt;
          cnt   <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            valid_DM  <= 1'b1;
            rd_DM     <= cap_rd;
            result_DM <= final_res;
            state     <= IDLE;
          end else begin
            valid_DM <= 1'b0;
            rd_DM    <= 5'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed vectors for ex_alu_stage, table-driven for
// single-cycle ops plus hand sequences for multi-cycle, flush and reset.
module tb_ex_alu_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        valid_in;
  logic [4:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] imm;
  logic        is_imm;
  logic [4:0]  rd_in;
  logic        stall;
  logic        valid_DM;
  logic [4:0]  rd_DM;
  logic [31:0] result_DM;
  logic        flag_E;
  logic        flag_GT;

  int passCount;
  int totalCount;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        is_imm;
    logic [4:0]  rd;
    logic [4:0]  exp_rd;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[14];

  ex_alu_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .op(op),
    .A(A), .B(B), .imm(imm), .is_imm(is_imm), .rd_in(rd_in),
    .stall(stall), .valid_DM(valid_DM), .rd_DM(rd_DM), .result_DM(result_DM),
    .flag_E(flag_E), .flag_GT(flag_GT)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // drive one instruction, advance one edge and sample 1ns later
  task automatic applyStimulus(input logic v, input logic [4:0] o,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] im, input logic ii,
                               input logic [4:0] rd);
    valid_in = v; op = o; A = a; B = b; imm = im; is_imm = ii; rd_in = rd;
    @(posedge clk);
    #1;
  endtask

  // issue a multi-cycle op with a follow-on add held behind it
  task automatic runMulti(input string name, input logic [4:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] expected);
    int stallCycles;
    int leaks;
    stallCycles = 0;
    leaks = 0;
    applyStimulus(1'b1, o, a, b, 32'd0, 1'b0, rd);
    valid_in = 1'b1; op = 5'd0; A = 32'd2; B = 32'd3; is_imm = 1'b0; rd_in = 5'd6;
    for (int i = 0; i < 40; i++) begin
      if (!stall) break;
      stallCycles++;
      if (valid_DM !== 1'b0 || rd_DM !== 5'd0) leaks++;
      @(posedge clk);
      #1;
    end
    checkOutput({name, " stall cycles"}, stallCycles, 32);
    checkOutput({name, " bubbles while busy"}, leaks, 0);
    checkOutput({name, " rd"}, {27'd0, rd_DM}, {27'd0, rd});
    checkOutput({name, " result"}, result_DM, expected);
    checkOutput({name, " valid"}, {31'd0, valid_DM}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput({name, " held add rd"}, {27'd0, rd_DM}, 32'd6);
    checkOutput({name, " held add result"}, result_DM, 32'd5);
  endtask

  initial begin
    passCount = 0;
    totalCount = 0;

    vecs[0]  = '{5'd0,  32'd5,          32'd7,          32'd0,          1'b0, 5'd3,  5'd3,  32'd12};
    vecs[1]  = '{5'd1,  32'd10,         32'd3,          32'd0,          1'b0, 5'd5,  5'd5,  32'd7};
    vecs[2]  = '{5'd6,  32'h0000_F0F0,  32'h0000_FF00,  32'd0,          1'b0, 5'd1,  5'd1,  32'h0000_F000};
    vecs[3]  = '{5'd7,  32'h0000_F0F0,  32'h0000_FF00,  32'd0,          1'b0, 5'd2,  5'd2,  32'h0000_FFF0};
    vecs[4]  = '{5'd8,  32'h1234_5678,  32'd0,          32'd0,          1'b0, 5'd8,  5'd8,  32'hFFFF_FFFF};
    vecs[5]  = '{5'd9,  32'd99,         32'd0,          32'h0000_1234,  1'b1, 5'd9,  5'd9,  32'h0000_1234};
    vecs[6]  = '{5'd10, 32'd1,          32'd31,         32'd0,          1'b0, 5'd10, 5'd10, 32'h8000_0000};
    vecs[7]  = '{5'd11, 32'h8000_0000,  32'd4,          32'd0,          1'b0, 5'd11, 5'd11, 32'h0800_0000};
    vecs[8]  = '{5'd12, 32'h8000_0000,  32'd4,          32'd0,          1'b0, 5'd12, 5'd12, 32'hF800_0000};
    vecs[9]  = '{5'd20, 32'd100,        32'd0,          32'hFFFF_FFFC,  1'b1, 5'd13, 5'd13, 32'd96};
    vecs[10] = '{5'd0,  32'd1,          32'd2,          32'd0,          1'b0, 5'd0,  5'd0,  32'd3};
    vecs[11] = '{5'd3,  32'd9,          32'd0,          32'd0,          1'b0, 5'd14, 5'd14, 32'hFFFF_FFFF};
    vecs[12] = '{5'd4,  32'd9,          32'd0,          32'd0,          1'b0, 5'd15, 5'd15, 32'd9};
    vecs[13] = '{5'd13, 32'd55,         32'd66,         32'd0,          1'b0, 5'd16, 5'd0,  32'd9};

    rst = 1'b1; flush = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("reset outputs",
                {21'd0, stall, valid_DM, rd_DM, flag_E, flag_GT, 2'd0}, 32'd0);
    checkOutput("reset result", result_DM, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm,
                    vecs[i].is_imm, vecs[i].rd);
      checkOutput($sformatf("vec%0d rd", i), {27'd0, rd_DM}, {27'd0, vecs[i].exp_rd});
      checkOutput($sformatf("vec%0d result", i), result_DM, vecs[i].exp_res);
      checkOutput($sformatf("vec%0d valid/stall", i), {30'd0, valid_DM, stall}, 32'd2);
    end

    applyStimulus(1'b1, 5'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd7);
    checkOutput("cmp -1,1 flags", {30'd0, flag_E, flag_GT}, 32'd0);
    checkOutput("cmp -1,1 rd", {27'd0, rd_DM}, 32'd0);
    checkOutput("cmp -1,1 result held", result_DM, 32'd9);
    applyStimulus(1'b1, 5'd5, 32'd5, 32'd5, 32'd0, 1'b0, 5'd7);
    checkOutput("cmp 5,5 flags", {30'd0, flag_E, flag_GT}, 32'd2);
    applyStimulus(1'b1, 5'd5, 32'd7, 32'hFFFF_FFFD, 32'd0, 1'b0, 5'd7);
    checkOutput("cmp 7,-3 flags", {30'd0, flag_E, flag_GT}, 32'd1);

    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("idle bubble", {26'd0, valid_DM, rd_DM}, 32'd0);
    checkOutput("idle result held", result_DM, 32'd9);

    runMulti("mul", 5'd2, 32'd123456, 32'd789, 5'd4, 32'd97406784);
    runMulti("div", 5'd3, 32'd100, 32'd7, 5'd11, 32'd14);
    runMulti("mod", 5'd4, 32'd100, 32'd7, 5'd12, 32'd2);
    runMulti("div big", 5'd3, 32'hFFFF_FFFF, 32'h8000_0000, 5'd17, 32'd1);

    // flush on the 10th busy cycle of a div
    applyStimulus(1'b1, 5'd3, 32'd100, 32'd7, 32'd0, 1'b0, 5'd7);
    valid_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre-flush stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush stall", {31'd0, stall}, 32'd0);
    checkOutput("flush bubble", {26'd0, valid_DM, rd_DM}, 32'd0);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("flushed div never writes", {26'd0, valid_DM, rd_DM}, 32'd0);
    checkOutput("flushed result held", result_DM, 32'd5);

    flush = 1'b1;
    applyStimulus(1'b1, 5'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd9);
    flush = 1'b0;
    checkOutput("flushed add dropped", {26'd0, valid_DM, rd_DM}, 32'd0);
    checkOutput("flushed add result held", result_DM, 32'd5);
    checkOutput("flush keeps flags", {30'd0, flag_E, flag_GT}, 32'd1);

    // reset during the 20th iteration of a mul
    applyStimulus(1'b1, 5'd2, 32'd123456, 32'd789, 32'd0, 1'b0, 5'd4);
    valid_in = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("mid-busy reset outputs",
                {21'd0, stall, valid_DM, rd_DM, flag_E, flag_GT, 2'd0}, 32'd0);
    checkOutput("mid-busy reset result", result_DM, 32'd0);
    applyStimulus(1'b1, 5'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd2);
    checkOutput("post-reset add rd", {27'd0, rd_DM}, 32'd2);
    checkOutput("post-reset add result", result_DM, 32'd2);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Execute stage of the SimpleRISC pipeline, directly downstream of the operand forwarding unit. It consumes the forwarded operands A/B, computes single-cycle ALU results, and runs iterative 32-step multiply, divide and modulo. It drives the EX/DM pipeline register (`rd_DM`, `result_DM`), which the forwarding unit reads back, and raises `stall` to hold upstream stages while a multi-cycle operation is in flight.

## Interface
Parameters:
- `WIDTH`, 32, datapath width. Only 32 is supported; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous kill of the in-flight or incoming op (branch redirect)
- `valid_in`  in  1  an instruction is presented this cycle
- `op`  in  5  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 cmp, 6 and, 7 or, 8 not, 9 mov, 10 lsl, 11 lsr, 12 asr, 13 nop, 14–31 address add
- `A`  in  32  forwarded operand 1
- `B`  in  32  forwarded operand 2
- `imm`  in  32  sign-extended immediate
- `is_imm`  in  1  selects op2 = `imm`; otherwise op2 = `B`
- `rd_in`  in  5  destination register; 0 means no write
- `stall`  out  1  upstream must hold its current instruction
- `valid_DM`  out  1  EX/DM register holds a real instruction
- `rd_DM`  out  5  EX/DM destination; 0 on bubbles
- `result_DM`  out  32  EX/DM result
- `flag_E`  out  1  last cmp: operands equal
- `flag_GT`  out  1  last cmp: A > op2, signed

## Operation
- State machine: IDLE and BUSY.
- **IDLE, `valid_in`=1, single-cycle op.** At the edge, register `valid_DM`=1, `rd_DM`=`rd_in`, and `result_DM` as follows:
  - add: A+op2
  - sub: A−op2
  - and / or
  - not: ~op2
  - mov: op2
  - lsl / lsr / asr: shift A by op2[4:0]
  - ops 14–31: A+op2, used for ld/st address
- **nop.** Produces a bubble: `valid_DM`=1, `rd_DM`=0.
- **cmp.** Updates `flag_E` and `flag_GT` at the edge, forces `rd_DM`=0, and leaves `result_DM` unchanged.
- **IDLE, `valid_in`=1, op 2/3/4.** Capture A, op2, `rd_in` and op. Load the iteration counter with 32 and enter BUSY. The EX/DM register takes a bubble (`valid_DM`=0, `rd_DM`=0).
- **mul.** Shift-add, one multiplier bit per cycle. Keeps the low 32 bits of the unsigned product.
- **div/mod.** Unsigned restoring division, one quotient bit per cycle. div returns the quotient; mod returns the remainder.
- **Divide by zero.** The unit does not enter BUSY. It completes in one cycle like an ALU op: div gives 32'hFFFF_FFFF, mod gives A.
- **BUSY.** One iteration per edge.
  - `stall`=1 combinationally for the whole time state is BUSY.
  - EX/DM holds a bubble on every BUSY edge except the last.
  - On the edge where the counter goes 1→0, EX/DM loads `valid_DM`=1, `rd_DM`=captured rd, `result_DM`=final value, and the state returns to IDLE.
  - Inputs are ignored while BUSY.
- **`valid_in`=0 in IDLE.** Bubble: `valid_DM`=0, `rd_DM`=0, `result_DM` held.
- **`flush`=1.** Overrides everything except `rst`:
  - state → IDLE, counter cleared;
  - EX/DM takes a bubble;
  - the incoming instruction is dropped;
  - flags are not changed.
- **`rst`=1.** State IDLE, counter 0, `stall`=0, `valid_DM`=0, `rd_DM`=0, `result_DM`=0, `flag_E`=0, `flag_GT`=0. This applies even mid-BUSY.
- **`rd_in`=0 with a valid write op.** The result is registered but `rd_DM` stays 0, so the forwarding unit never matches it.

## Timing
- Single-cycle ops: accepted at edge k; result visible on `rd_DM`/`result_DM` after edge k.
- Multi-cycle ops: accepted at edge k; iterations run on edges k+1…k+32; result visible after edge k+32.
- `stall` is high from after edge k until edge k+32. The next instruction is accepted at edge k+33 at the earliest.
- `stall` is a Moore output (state==BUSY only). There is no combinational path from inputs to `stall`.
- Back-to-back single-cycle ops sustain 1 per cycle.
- A mul immediately after a mul starts at edge k+33.

## Test plan
- **Reset:** assert `rst` for 2 cycles → all outputs 0, `stall`=0.
- **Single-cycle ops:**
  - add A=5, op2=7, rd=3 → after 1 edge `rd_DM`=3, `result_DM`=12.
  - asr A=32'h8000_0000 by 4 → 32'hF800_0000.
  - cmp A=−1, B=1 → `flag_E`=0, `flag_GT`=0, `rd_DM`=0.
- **mul:** A=123456, B=789, rd=4 → `stall`=1 for exactly 32 cycles, bubbles on EX/DM meanwhile. After edge k+32: `rd_DM`=4, `result_DM`=97406784. An instruction held during stall issues at k+33.
- **div/mod:**
  - div 100/7 → 14; mod 100/7 → 2, each with 32-cycle stall.
  - div 9/0 → 32'hFFFF_FFFF in 1 cycle, `stall` never high.
  - mod 9/0 → 9.
- **Flush:** `flush` at the 10th BUSY cycle of a div → next edge IDLE, `stall`=0, `rd_DM`=0, no result written. `flush` together with `valid_in`=1 add → add dropped.
- **Reset mid-BUSY:** `rst` during the 20th iteration → all outputs 0 next edge. A following add A=1, B=1 issues normally and gives 2.
